// File: rtl/id_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : id_issue_buffer
// Purpose  : Decode / register-read stage with a DEPTH-entry instruction queue
//            between fetch and execute.  The head entry is decoded, its rs/rt
//            operands are read from the GRF and patched by NFWD forward
//            channels (channel 0 = youngest, highest priority), and it is
//            issued into a registered EX slot under valid/ready handshaking.
// Ports    : clk, rst_n (async, active-low), flush
//            in_*        fetch push interface (valid/ready, code, pc, exc, bd)
//            fwd_*       forward channels (addr, data, pending), packed
//            ra1/ra2     GRF read addresses, rd1/rd2 GRF read data
//            head_instr  decoded head symbol (NOP when empty), head_cmp
//            out_*       registered EX slot (valid/ready + decoded fields)
// Revision : 1.0 - initial release
// ============================================================================
module id_issue_buffer #(
  parameter  int DEPTH       = 4,
  parameter  int NFWD        = 2,
  parameter  int XLEN        = 32,
  localparam int WIDTH_INSTR = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_code,
  input  logic [31:0]            in_pc,
  input  logic [4:0]             in_exc,
  input  logic                   in_bd,
  input  logic [NFWD*5-1:0]      fwd_addr,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  input  logic [NFWD-1:0]        fwd_pending,
  output logic [4:0]             ra1,
  output logic [4:0]             ra2,
  input  logic [XLEN-1:0]        rd1,
  input  logic [XLEN-1:0]        rd2,
  output logic [WIDTH_INSTR-1:0] head_instr,
  output logic                   head_cmp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH_INSTR-1:0] out_instr,
  output logic [31:0]            out_pc,
  output logic [4:0]             out_exc,
  output logic                   out_bd,
  output logic [XLEN-1:0]        out_rs_data,
  output logic [XLEN-1:0]        out_rt_data,
  output logic [15:0]            out_imm16,
  output logic [4:0]             out_shamt,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Decoded instruction symbols
  localparam logic [WIDTH_INSTR-1:0] c_i_nop   = 5'd0;
  localparam logic [WIDTH_INSTR-1:0] c_i_addu  = 5'd1;
  localparam logic [WIDTH_INSTR-1:0] c_i_subu  = 5'd2;
  localparam logic [WIDTH_INSTR-1:0] c_i_and   = 5'd3;
  localparam logic [WIDTH_INSTR-1:0] c_i_or    = 5'd4;
  localparam logic [WIDTH_INSTR-1:0] c_i_slt   = 5'd5;
  localparam logic [WIDTH_INSTR-1:0] c_i_sll   = 5'd6;
  localparam logic [WIDTH_INSTR-1:0] c_i_jr    = 5'd7;
  localparam logic [WIDTH_INSTR-1:0] c_i_ori   = 5'd8;
  localparam logic [WIDTH_INSTR-1:0] c_i_lui   = 5'd9;
  localparam logic [WIDTH_INSTR-1:0] c_i_lw    = 5'd10;
  localparam logic [WIDTH_INSTR-1:0] c_i_sw    = 5'd11;
  localparam logic [WIDTH_INSTR-1:0] c_i_beq   = 5'd12;
  localparam logic [WIDTH_INSTR-1:0] c_i_bne   = 5'd13;
  localparam logic [WIDTH_INSTR-1:0] c_i_j     = 5'd14;
  localparam logic [WIDTH_INSTR-1:0] c_i_jal   = 5'd15;
  localparam logic [WIDTH_INSTR-1:0] c_i_addiu = 5'd16;

  localparam logic [4:0] c_exc_ri = 5'd10;

  // --------------------------------------------------------------------------
  // Queue storage and pointers
  // --------------------------------------------------------------------------
  logic [31:0]   r_q_code [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [4:0]    r_q_exc  [DEPTH];
  logic          r_q_bd   [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_head_valid;
  logic w_push;
  logic w_issue;
  logic w_hazard;

  assign w_head_valid = (r_count != '0);
  // Full is judged on the registered count only, so a same-cycle pop never
  // frees a slot combinationally.
  assign in_ready     = (r_count != CW'(DEPTH));
  assign w_push       = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_q_code[r_wr_ptr] <= in_code;
      r_q_pc[r_wr_ptr]   <= in_pc;
      r_q_exc[r_wr_ptr]  <= in_exc;
      r_q_bd[r_wr_ptr]   <= in_bd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  logic [31:0] w_code;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;

  assign w_code  = r_q_code[r_rd_ptr];
  assign w_op    = w_code[31:26];
  assign w_rs    = w_code[25:21];
  assign w_rt    = w_code[20:16];
  assign w_rd    = w_code[15:11];
  assign w_shamt = w_code[10:6];
  assign w_funct = w_code[5:0];
  assign w_imm   = w_code[15:0];

  logic [WIDTH_INSTR-1:0] w_dec_instr;
  logic                   w_dec_ri;

  always_comb begin
    w_dec_instr = c_i_nop;
    w_dec_ri    = 1'b0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h21:   w_dec_instr = c_i_addu;
          6'h23:   w_dec_instr = c_i_subu;
          6'h24:   w_dec_instr = c_i_and;
          6'h25:   w_dec_instr = c_i_or;
          6'h2a:   w_dec_instr = c_i_slt;
          6'h00:   w_dec_instr = c_i_sll;
          6'h08:   w_dec_instr = c_i_jr;
          default: w_dec_ri    = 1'b1;
        endcase
      end
      6'h02:   w_dec_instr = c_i_j;
      6'h03:   w_dec_instr = c_i_jal;
      6'h04:   w_dec_instr = c_i_beq;
      6'h05:   w_dec_instr = c_i_bne;
      6'h09:   w_dec_instr = c_i_addiu;
      6'h0d:   w_dec_instr = c_i_ori;
      6'h0f:   w_dec_instr = c_i_lui;
      6'h23:   w_dec_instr = c_i_lw;
      6'h2b:   w_dec_instr = c_i_sw;
      default: w_dec_ri    = 1'b1;
    endcase
    // All-zero word is the canonical NOP rather than sll $0,$0,0
    if (w_code == 32'h0) w_dec_instr = c_i_nop;
  end

  // --------------------------------------------------------------------------
  // Operand read and forwarding.  Channels are scanned from the oldest down
  // so the lowest-numbered match overwrites and wins.  $0 is hard-wired 0.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic            w_rs_pend;
  logic            w_rt_pend;

  assign ra1 = w_head_valid ? w_rs : 5'd0;
  assign ra2 = w_head_valid ? w_rt : 5'd0;

  always_comb begin
    w_rs_data = (w_rs == 5'd0) ? '0 : rd1;
    w_rt_data = (w_rt == 5'd0) ? '0 : rd2;
    w_rs_pend = 1'b0;
    w_rt_pend = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if ((w_rs != 5'd0) && (fwd_addr[i*5 +: 5] == w_rs)) begin
        w_rs_data = fwd_data[i*XLEN +: XLEN];
        w_rs_pend = fwd_pending[i];
      end
      if ((w_rt != 5'd0) && (fwd_addr[i*5 +: 5] == w_rt)) begin
        w_rt_data = fwd_data[i*XLEN +: XLEN];
        w_rt_pend = fwd_pending[i];
      end
    end
  end

  // Hazard is conservative: any pending match stalls, whether or not the
  // instruction actually consumes that operand.
  assign w_hazard = w_head_valid & (w_rs_pend | w_rt_pend);
  assign w_issue  = w_head_valid & ~w_hazard & (~out_valid | out_ready) & ~flush;

  logic w_cmp;
  always_comb begin
    w_cmp = 1'b0;
    if (w_dec_instr == c_i_beq) w_cmp = (w_rs_data == w_rt_data);
    if (w_dec_instr == c_i_bne) w_cmp = (w_rs_data != w_rt_data);
  end

  assign head_instr = w_head_valid ? w_dec_instr : c_i_nop;
  assign head_cmp   = w_head_valid & w_cmp;

  // Fetch exceptions take precedence over a reserved-instruction fault.
  logic [4:0] w_head_exc;
  assign w_head_exc = (r_q_exc[r_rd_ptr] != 5'd0) ? r_q_exc[r_rd_ptr] :
                      (w_dec_ri ? c_exc_ri : 5'd0);

  // --------------------------------------------------------------------------
  // EX slot
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_exc     <= '0;
      out_bd      <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm16   <= '0;
      out_shamt   <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_issue) begin
      out_valid   <= 1'b1;
      out_instr   <= w_dec_instr;
      out_pc      <= r_q_pc[r_rd_ptr];
      out_exc     <= w_head_exc;
      out_bd      <= r_q_bd[r_rd_ptr];
      out_rs_data <= w_rs_data;
      out_rt_data <= w_rt_data;
      out_imm16   <= w_imm;
      out_shamt   <= w_shamt;
      out_rs      <= w_rs;
      out_rt      <= w_rt;
      out_rd      <= w_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_issue_buffer
// Purpose  : Directed self-checking bench for id_issue_buffer.  A behavioural
//            GRF returns 0xA000_0000 | addr for every register (including $0,
//            so hard-wired zero behaviour is visible).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_issue_buffer;

  localparam int NFWD = 2;
  localparam int XLEN = 32;

  localparam logic [4:0] c_i_nop  = 5'd0;
  localparam logic [4:0] c_i_addu = 5'd1;
  localparam logic [4:0] c_i_beq  = 5'd12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_code;
  logic [31:0]     in_pc;
  logic [4:0]      in_exc;
  logic            in_bd;
  logic [NFWD*5-1:0]    fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_pending;
  logic [4:0]      ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;
  logic [4:0]      head_instr;
  logic            head_cmp;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_instr;
  logic [31:0]     out_pc;
  logic [4:0]      out_exc;
  logic            out_bd;
  logic [XLEN-1:0] out_rs_data, out_rt_data;
  logic [15:0]     out_imm16;
  logic [4:0]      out_shamt, out_rs, out_rt, out_rd;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign rd1 = 32'hA000_0000 | {27'd0, ra1};
  assign rd2 = 32'hA000_0000 | {27'd0, ra2};

  id_issue_buffer #(.DEPTH(4), .NFWD(NFWD), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .head_instr(head_instr), .head_cmp(head_cmp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc), .out_bd(out_bd),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_imm16(out_imm16), .out_shamt(out_shamt),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] code, input logic [31:0] pc,
                            input logic [4:0] exc, input logic bd);
    in_valid = 1'b1;
    in_code  = code;
    in_pc    = pc;
    in_exc   = exc;
    in_bd    = bd;
  endtask

  // Push one entry, then give it one edge to issue.
  task automatic push_and_issue(input logic [31:0] code, input logic [31:0] pc,
                                input logic [4:0] exc, input logic bd);
    drive_push(code, pc, exc, bd);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h21};
  endfunction

  function automatic logic [31:0] mk_beq(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h04, rs, rt, 16'h0004};
  endfunction

  int pushed, consumed, qcount;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_code = '0; in_pc = '0;
    in_exc = '0; in_bd = 1'b0; fwd_addr = '0; fwd_data = '0; fwd_pending = '0;
    out_ready = 1'b0;

    // ---------------- 1: reset, fill, full, hold, drain ----------------
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_head_instr", {27'd0, head_instr}, {27'd0, c_i_nop});
    check("rst_head_cmp", {31'd0, head_cmp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      drive_push(mk_r(5'd1, 5'd2, 5'd3), 32'h100 + 32'(4 * k), 5'd0, 1'b0);
      #1;
      check("t1_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive_push(mk_r(5'd1, 5'd2, 5'd3), 32'h114, 5'd0, 1'b0);
    #1;
    check("t1_full_ready", {31'd0, in_ready}, 32'd0);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_pc", out_pc, 32'h100);
    check("t1_head_instr", {27'd0, head_instr}, {27'd0, c_i_addu});
    tick();
    check("t1_hold_pc", out_pc, 32'h100);
    check("t1_rs_data", out_rs_data, 32'hA000_0001);
    check("t1_rd", {27'd0, out_rd}, 32'd3);
    check("t1_bd", {31'd0, out_bd}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t1_full_pop_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      check("t1_drain_pc", out_pc, 32'h100 + 32'(4 * k));
      check("t1_drain_valid", {31'd0, out_valid}, 32'd1);
    end
    tick();
    check("t1_empty_valid", {31'd0, out_valid}, 32'd0);
    check("t1_empty_nop", {27'd0, head_instr}, {27'd0, c_i_nop});

    // ---------------- 2: pointer wrap with toggling out_ready ----------------
    pushed = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 60 && consumed < 10; cyc++) begin
      in_valid  = (pushed < 10);
      in_pc     = 32'h200 + 32'(4 * pushed);
      in_code   = mk_r(5'd1, 5'd2, 5'd3);
      in_exc    = 5'd0;
      in_bd     = 1'b0;
      out_ready = (cyc % 2 == 0);
      #1;
      qcount = pushed - consumed - (out_valid ? 1 : 0);
      check("t2_qcount_le4", {31'd0, (qcount <= 4)}, 32'd1);
      check("t2_in_ready", {31'd0, in_ready}, {31'd0, (qcount < 4)});
      if (out_valid && out_ready) begin
        check("t2_out_pc", out_pc, 32'h200 + 32'(4 * consumed));
        consumed++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
    end
    check("t2_pushed", 32'(pushed), 32'd10);
    check("t2_consumed", 32'(consumed), 32'd10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("t2_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- 3: forwarding priority and $0 ----------------
    fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11}; fwd_pending = 2'b00;
    push_and_issue(mk_r(5'd5, 5'd3, 5'd4), 32'h300, 5'd0, 1'b0);
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_pc", out_pc, 32'h300);
    check("t3_rs_ch0", out_rs_data, 32'h11);
    check("t3_rt_grf", out_rt_data, 32'hA000_0003);
    fwd_addr = {5'd5, 5'd0}; fwd_data = {32'h22, 32'hFF};
    push_and_issue(mk_r(5'd0, 5'd5, 5'd4), 32'h304, 5'd0, 1'b0);
    check("t3_rs_zero", out_rs_data, 32'h0);
    check("t3_rt_ch1", out_rt_data, 32'h22);
    fwd_addr = {5'd7, 5'd5}; fwd_data = {32'h77, 32'h55};
    push_and_issue(mk_r(5'd7, 5'd5, 5'd4), 32'h308, 5'd0, 1'b0);
    check("t3_rs_ch1_only", out_rs_data, 32'h77);
    check("t3_rt_ch0", out_rt_data, 32'h55);
    tick();
    check("t3_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- 4: pending hazard ----------------
    fwd_addr = {5'd8, 5'd0}; fwd_data = {32'h88, 32'hFF}; fwd_pending = 2'b10;
    drive_push(mk_r(5'd8, 5'd0, 5'd4), 32'h400, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stall", {31'd0, out_valid}, 32'd0);
    end
    fwd_pending = 2'b00;
    tick();
    check("t4_issue", {31'd0, out_valid}, 32'd1);
    check("t4_pc", out_pc, 32'h400);
    check("t4_rs_fwd", out_rs_data, 32'h88);
    tick();

    // ---------------- 5: compare and exception encoding ----------------
    fwd_addr = {5'd10, 5'd9}; fwd_data = {32'h55, 32'h55};
    drive_push(mk_beq(5'd9, 5'd10), 32'h500, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("t5_head_beq", {27'd0, head_instr}, {27'd0, c_i_beq});
    check("t5_cmp_eq", {31'd0, head_cmp}, 32'd1);
    tick();
    check("t5_out_beq", {27'd0, out_instr}, {27'd0, c_i_beq});
    check("t5_exc_none", {27'd0, out_exc}, 32'd0);
    fwd_data = {32'h56, 32'h55};
    drive_push(mk_beq(5'd9, 5'd10), 32'h504, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("t5_cmp_ne", {31'd0, head_cmp}, 32'd0);
    tick();
    push_and_issue(32'hFC00_0000, 32'h508, 5'd0, 1'b1);
    check("t5_exc_ri", {27'd0, out_exc}, 32'd10);
    check("t5_ri_nop", {27'd0, out_instr}, {27'd0, c_i_nop});
    check("t5_bd", {31'd0, out_bd}, 32'd1);
    push_and_issue(mk_r(5'd1, 5'd2, 5'd3), 32'h50C, 5'd4, 1'b0);
    check("t5_exc_fetch", {27'd0, out_exc}, 32'd4);
    push_and_issue(32'hFC00_0000, 32'h510, 5'd4, 1'b0);
    check("t5_exc_prio", {27'd0, out_exc}, 32'd4);
    tick();

    // ---------------- 6: flush ----------------
    fwd_addr = '0; fwd_data = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_push(mk_r(5'd1, 5'd2, 5'd3), 32'h600 + 32'(4 * k), 5'd0, 1'b0);
      tick();
    end
    check("t6_slot_valid", {31'd0, out_valid}, 32'd1);
    check("t6_slot_pc", out_pc, 32'h600);
    drive_push(mk_r(5'd1, 5'd2, 5'd3), 32'h6F0, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    check("t6_ready_in_flush", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_head_nop", {27'd0, head_instr}, {27'd0, c_i_nop});
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("t6_no_survivor", {31'd0, out_valid}, 32'd0);
    push_and_issue(mk_r(5'd1, 5'd2, 5'd3), 32'h700, 5'd0, 1'b0);
    check("t6_post_valid", {31'd0, out_valid}, 32'd1);
    check("t6_post_pc", out_pc, 32'h700);
    tick();

    // ---------------- 7: asynchronous reset mid-operation ----------------
    out_ready = 1'b0;
    drive_push(mk_r(5'd1, 5'd2, 5'd3), 32'h800, 5'd0, 1'b0);
    tick();
    drive_push(mk_r(5'd1, 5'd2, 5'd3), 32'h804, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_valid", {31'd0, out_valid}, 32'd0);
    check("t7_pc", out_pc, 32'd0);
    check("t7_in_ready", {31'd0, in_ready}, 32'd1);
    check("t7_head_nop", {27'd0, head_instr}, {27'd0, c_i_nop});
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("t7_no_survivor", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
